// File: rtl/ctrl_sequencer.sv
// Multi-cycle instruction sequencer: fetches 9-bit instructions over a req/valid
// handshake, drives an external combinational ALU and writes results to a 4-entry register file.
module ctrl_sequencer #(
    parameter int unsigned W   = 8,
    parameter int unsigned Ops = 4,
    parameter int unsigned PCW = 10
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           Start,
    output logic [PCW-1:0] InstAddr,
    output logic           InstReq,
    input  logic [8:0]     Instr,
    input  logic           InstValid,
    output logic [W-1:0]   AluA,
    output logic [W-1:0]   AluB,
    output logic [Ops-1:0] AluOp,
    input  logic [W-1:0]   AluOut,
    input  logic           AluJump,
    output logic           Done,
    output logic           Error,
    output logic [15:0]    CycleCount
);

    localparam int unsigned IW = 9;
    localparam int unsigned CW = 16;
    localparam int unsigned NR = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] OP_ADD      = 4'h0;
    localparam logic [3:0] OP_BEQ      = 4'h3;
    localparam logic [3:0] OP_BNE      = 4'h4;
    localparam logic [3:0] OP_LAST_ALU = 4'h9;
    localparam logic [3:0] OP_LDI      = 4'hE;
    localparam logic [3:0] OP_HALT     = 4'hF;

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [1:0]     r_state;
    logic [PCW-1:0] r_pc;
    logic [IW-1:0]  r_instr;
    logic [W-1:0]   r_regs [NR];
    logic           r_req;
    logic [W-1:0]   r_alu_a;
    logic [W-1:0]   r_alu_b;
    logic [Ops-1:0] r_alu_op;
    logic           r_done;
    logic           r_error;
    logic [CW-1:0]  r_count;

    logic [1:0]     w_state_nxt;
    logic [PCW-1:0] w_pc_nxt;
    logic [IW-1:0]  w_instr_nxt;
    logic [W-1:0]   w_regs_nxt [NR];
    logic           w_req_nxt;
    logic [W-1:0]   w_alu_a_nxt;
    logic [W-1:0]   w_alu_b_nxt;
    logic [Ops-1:0] w_alu_op_nxt;
    logic           w_done_nxt;
    logic           w_error_nxt;
    logic [CW-1:0]  w_count_nxt;

    logic [PCW-1:0] w_pc_inc;
    logic [CW-1:0]  w_count_inc;
    logic [3:0]     w_f_op;
    logic [1:0]     w_f_ra;
    logic [1:0]     w_f_rb;
    logic [3:0]     w_x_op;
    logic [1:0]     w_x_ra;
    logic           w_x_is_br;
    logic           w_x_is_alu;

    assign w_pc_inc    = r_pc + PCW'(1);
    assign w_count_inc = (r_count == CNT_MAX) ? r_count : r_count + CW'(1);

    // Fetch-side decode picks operands so they are registered for the EXEC cycle.
    assign w_f_op = Instr[8:5];
    assign w_f_ra = Instr[4:3];
    assign w_f_rb = Instr[2:1];

    assign w_x_op     = r_instr[8:5];
    assign w_x_ra     = r_instr[4:3];
    assign w_x_is_br  = (w_x_op == OP_BEQ) || (w_x_op == OP_BNE);
    assign w_x_is_alu = (w_x_op <= OP_LAST_ALU);

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_instr_nxt  = r_instr;
        w_regs_nxt   = r_regs;
        w_req_nxt    = r_req;
        w_alu_a_nxt  = '0;
        w_alu_b_nxt  = '0;
        w_alu_op_nxt = Ops'(OP_ADD);
        w_done_nxt   = r_done;
        w_error_nxt  = r_error;
        w_count_nxt  = r_count;

        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_state_nxt = S_FETCH;
                    w_pc_nxt    = '0;
                    w_count_nxt = '0;
                    w_req_nxt   = 1'b1;
                end
            end

            S_FETCH: begin
                w_count_nxt = w_count_inc;
                if (InstValid) begin
                    w_instr_nxt = Instr;
                    w_state_nxt = S_EXEC;
                    w_req_nxt   = 1'b0;
                    if (w_f_op <= OP_LAST_ALU) begin
                        w_alu_op_nxt = Ops'(w_f_op);
                        w_alu_a_nxt  = r_regs[w_f_ra];
                        w_alu_b_nxt  = r_regs[w_f_rb];
                    end
                end
            end

            S_EXEC: begin
                w_count_nxt = w_count_inc;
                w_state_nxt = S_FETCH;
                w_req_nxt   = 1'b1;
                if (w_x_is_br) begin
                    w_pc_nxt = AluJump ? PCW'(r_regs[3]) : w_pc_inc;
                end else if (w_x_is_alu) begin
                    w_regs_nxt[w_x_ra] = AluOut;
                    w_pc_nxt           = w_pc_inc;
                end else if (w_x_op == OP_LDI) begin
                    w_regs_nxt[w_x_ra] = W'(r_instr[2:0]);
                    w_pc_nxt           = w_pc_inc;
                end else if (w_x_op == OP_HALT) begin
                    w_state_nxt = S_DONE;
                    w_req_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    // 0xA-0xD: halt with sticky error, PC left on the offender
                    w_state_nxt = S_DONE;
                    w_req_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_error_nxt = 1'b1;
                end
            end

            default: begin
                w_done_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_instr  <= '0;
            for (int i = 0; i < NR; i++) begin
                r_regs[i] <= '0;
            end
            r_req    <= 1'b0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= Ops'(OP_ADD);
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_instr  <= w_instr_nxt;
            r_regs   <= w_regs_nxt;
            r_req    <= w_req_nxt;
            r_alu_a  <= w_alu_a_nxt;
            r_alu_b  <= w_alu_b_nxt;
            r_alu_op <= w_alu_op_nxt;
            r_done   <= w_done_nxt;
            r_error  <= w_error_nxt;
            r_count  <= w_count_nxt;
        end
    end

    assign InstAddr   = r_pc;
    assign InstReq    = r_req;
    assign AluA       = r_alu_a;
    assign AluB       = r_alu_b;
    assign AluOp      = r_alu_op;
    assign Done       = r_done;
    assign Error      = r_error;
    assign CycleCount = r_count;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: acts as instruction memory and ALU, and checks the DUT
// against an instruction-level model of the program.
module tb_ctrl_sequencer;

    localparam logic [8:0] HALT = 9'h1E0;

    logic        Clk;
    logic        Reset_n;
    logic        Start;
    logic [9:0]  InstAddr;
    logic        InstReq;
    logic [8:0]  Instr;
    logic        InstValid;
    logic [7:0]  AluA;
    logic [7:0]  AluB;
    logic [3:0]  AluOp;
    logic [7:0]  AluOut;
    logic        AluJump;
    logic        Done;
    logic        Error;
    logic [15:0] CycleCount;
    logic        noise;
    logic [8:0]  alu_res;

    int total = 0;
    int bad   = 0;

    logic [8:0] mem [0:1023];
    int         halt_step = -1;
    int         exp_pc  [$];
    logic [8:0] exp_ins [$];
    logic [3:0] exp_op  [$];
    logic [7:0] exp_a   [$];
    logic [7:0] exp_b   [$];
    logic [7:0] m_r [4];
    int         m_pc;
    bit         m_halt;
    bit         m_err;

    ctrl_sequencer #(.W(8), .Ops(4), .PCW(10)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
        .InstAddr(InstAddr), .InstReq(InstReq), .Instr(Instr), .InstValid(InstValid),
        .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluOut(AluOut), .AluJump(AluJump),
        .Done(Done), .Error(Error), .CycleCount(CycleCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] o;
        logic       j;
        o = '0;
        j = 1'b0;
        case (op)
            4'd0: o = a + b;
            4'd1: o = a ^ b;
            4'd2: o = a | b;
            4'd3: j = (a == b);
            4'd4: j = (a != b);
            4'd5: o = a << b[2:0];
            4'd6: o = a >> b[2:0];
            4'd7: o = a ^ {b[3:0], b[7:4]};
            4'd8: o = a - b;
            4'd9: o = a & b;
            default: o = '0;
        endcase
        return {j, o};
    endfunction

    // External ALU; the jump flag is noise for non-branch ops so the DUT must ignore it there.
    always_comb begin
        alu_res = alu_f(AluOp, AluA, AluB);
        AluOut  = alu_res[7:0];
        AluJump = (AluOp == 4'd3 || AluOp == 4'd4) ? alu_res[8] : noise;
    end

    function automatic logic [8:0] ldi(input int ra, input int imm);
        return {4'hE, 2'(ra), 3'(imm)};
    endfunction

    function automatic logic [8:0] aop(input int op, input int ra, input int rb);
        return {4'(op), 2'(ra), 2'(rb), 1'($urandom_range(0, 1))};
    endfunction

    task automatic fill_halt;
        for (int a = 0; a < 1024; a++) mem[a] = HALT;
    endtask

    // Instruction-level model: what each executed instruction should look like.
    task automatic model(input int max_steps);
        int         pc;
        int         ra;
        int         rb;
        logic [8:0] ins;
        logic [3:0] op;
        logic [8:0] r;
        exp_pc.delete(); exp_ins.delete(); exp_op.delete(); exp_a.delete(); exp_b.delete();
        for (int i = 0; i < 4; i++) m_r[i] = '0;
        pc = 0; m_halt = 0; m_err = 0;
        for (int s = 0; s < max_steps && !m_halt; s++) begin
            ins = (s == halt_step) ? HALT : mem[pc];
            exp_pc.push_back(pc);
            exp_ins.push_back(ins);
            op = ins[8:5];
            ra = int'(ins[4:3]);
            rb = int'(ins[2:1]);
            if (op <= 4'd9) begin
                exp_op.push_back(op);
                exp_a.push_back(m_r[ra]);
                exp_b.push_back(m_r[rb]);
                r = alu_f(op, m_r[ra], m_r[rb]);
                if (op == 4'd3 || op == 4'd4) begin
                    pc = r[8] ? int'(m_r[3]) : (pc + 1) % 1024;
                end else begin
                    m_r[ra] = r[7:0];
                    pc = (pc + 1) % 1024;
                end
            end else begin
                exp_op.push_back(4'd0);
                exp_a.push_back(8'd0);
                exp_b.push_back(8'd0);
                if (op == 4'hE) begin
                    m_r[ra] = {5'b0, ins[2:0]};
                    pc = (pc + 1) % 1024;
                end else begin
                    m_halt = 1;
                    if (op != 4'hF) m_err = 1;
                end
            end
        end
        m_pc = pc;
    endtask

    task automatic do_reset;
        Reset_n = 1'b0; Start = 1'b0; InstValid = 1'b0; Instr = '0;
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    // Start the DUT, serve fetches with the given latency (0 = random 1..4) and check
    // every FETCH and EXEC cycle; optionally reset in the EXEC cycle of instruction abort_at.
    task automatic run_prog(input int max_steps, input int lat_fixed, input int abort_at);
        int lat_q [$];
        int idx;
        int wcnt;
        int budget;
        int exp_cnt;
        bit pend;
        model(max_steps);
        exp_cnt = 0;
        for (int i = 0; i < exp_pc.size(); i++) begin
            lat_q.push_back(lat_fixed > 0 ? lat_fixed : int'($urandom_range(1, 4)));
            exp_cnt += lat_q[i] + 1;
        end
        if (exp_cnt > 65535) exp_cnt = 65535;

        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        total++;
        if (InstReq !== 1'b1 || InstAddr !== 10'd0 || CycleCount !== 16'd0) begin
            bad++;
            $display("FAIL start: req=%0b addr=%0d cnt=%0d, want req=1 addr=0 cnt=0", InstReq, InstAddr, CycleCount);
        end

        idx = 0; wcnt = 0; pend = 0; budget = 0;
        while (idx < exp_pc.size()) begin
            noise     = 1'($urandom);
            InstValid = 1'b0;
            Instr     = 9'($urandom);
            if (pend) begin
                pend = 0;
                if (idx == abort_at) begin
                    Reset_n = 1'b0;
                    #1;
                    total++;
                    if (InstReq !== 1'b0 || Done !== 1'b0 || Error !== 1'b0 || CycleCount !== 16'd0 ||
                        InstAddr !== 10'd0 || AluOp !== 4'd0 || AluA !== 8'd0 || AluB !== 8'd0) begin
                        bad++;
                        $display("FAIL async_reset: req=%0b done=%0b err=%0b cnt=%0d addr=%0d op=%0d a=%0d b=%0d, want all 0",
                                 InstReq, Done, Error, CycleCount, InstAddr, AluOp, AluA, AluB);
                    end
                    @(negedge Clk);
                    Reset_n   = 1'b1;
                    InstValid = 1'b1;
                    Instr     = exp_ins[idx];
                    @(negedge Clk);
                    InstValid = 1'b0;
                    repeat (2) @(negedge Clk);
                    total++;
                    if (InstReq !== 1'b0 || Done !== 1'b0 || CycleCount !== 16'd0 || AluA !== 8'd0) begin
                        bad++;
                        $display("FAIL post_reset_idle: req=%0b done=%0b cnt=%0d a=%0d, want 0 0 0 0",
                                 InstReq, Done, CycleCount, AluA);
                    end
                    return;
                end
                total++;
                if (InstReq !== 1'b0 || InstAddr !== 10'(exp_pc[idx]) || AluOp !== exp_op[idx] ||
                    AluA !== exp_a[idx] || AluB !== exp_b[idx]) begin
                    bad++;
                    $display("FAIL exec[%0d]: req=%0b addr=%0d op=%0d a=%0d b=%0d, want req=0 addr=%0d op=%0d a=%0d b=%0d",
                             idx, InstReq, InstAddr, AluOp, AluA, AluB, exp_pc[idx], exp_op[idx], exp_a[idx], exp_b[idx]);
                end
                InstValid = 1'($urandom_range(0, 1));
                idx++;
            end else begin
                total++;
                if (InstReq !== 1'b1 || InstAddr !== 10'(exp_pc[idx]) || AluOp !== 4'd0 ||
                    AluA !== 8'd0 || AluB !== 8'd0) begin
                    bad++;
                    $display("FAIL fetch[%0d]: req=%0b addr=%0d op=%0d a=%0d b=%0d, want req=1 addr=%0d idle alu",
                             idx, InstReq, InstAddr, AluOp, AluA, AluB, exp_pc[idx]);
                end
                wcnt++;
                if (wcnt >= lat_q[idx]) begin
                    InstValid = 1'b1;
                    Instr     = exp_ins[idx];
                    wcnt      = 0;
                    pend      = 1;
                end
            end
            @(negedge Clk);
            budget++;
            if (budget > 20000) begin
                total++; bad++;
                $display("FAIL timeout: idx=%0d of %0d", idx, exp_pc.size());
                break;
            end
        end
        InstValid = 1'b0;
        total++;
        if (Done !== m_halt || Error !== m_err || CycleCount !== 16'(exp_cnt) || InstAddr !== 10'(m_pc)) begin
            bad++;
            $display("FAIL final: done=%0b err=%0b cnt=%0d addr=%0d, want done=%0b err=%0b cnt=%0d addr=%0d",
                     Done, Error, CycleCount, InstAddr, m_halt, m_err, exp_cnt, m_pc);
        end
    endtask

    task automatic test_reset;
        Reset_n = 1'b0; Start = 1'b1; InstValid = 1'b1; Instr = HALT; noise = 1'b0;
        @(negedge Clk);
        total++;
        if (InstReq !== 1'b0 || Done !== 1'b0 || Error !== 1'b0 || CycleCount !== 16'd0 ||
            InstAddr !== 10'd0 || AluOp !== 4'd0 || AluA !== 8'd0 || AluB !== 8'd0) begin
            bad++;
            $display("FAIL reset: req=%0b done=%0b err=%0b cnt=%0d addr=%0d op=%0d, want all 0",
                     InstReq, Done, Error, CycleCount, InstAddr, AluOp);
        end
        Start = 1'b0; InstValid = 1'b0;
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        total++;
        if (InstReq !== 1'b0 || Done !== 1'b0) begin
            bad++;
            $display("FAIL idle: req=%0b done=%0b, want 0 0", InstReq, Done);
        end
    endtask

    task automatic test_basic;
        do_reset();
        fill_halt();
        mem[0] = ldi(0, 5); mem[1] = ldi(1, 3); mem[2] = aop(0, 0, 1); mem[3] = HALT;
        run_prog(10, 1, -1);
        total++;
        if (Done !== 1'b1 || CycleCount !== 16'd8 || Error !== 1'b0 || dut.r_regs[0] !== 8'd8) begin
            bad++;
            $display("FAIL basic: done=%0b cnt=%0d err=%0b r0=%0d, want 1 8 0 8", Done, CycleCount, Error, dut.r_regs[0]);
        end
        // Start is ignored once halted
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        total++;
        if (Done !== 1'b1 || InstReq !== 1'b0 || CycleCount !== 16'd8) begin
            bad++;
            $display("FAIL done_sticky: done=%0b req=%0b cnt=%0d, want 1 0 8", Done, InstReq, CycleCount);
        end
    endtask

    task automatic test_branch;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            fill_halt();
            mem[0] = ldi(3, 6); mem[1] = ldi(0, 2); mem[2] = ldi(1, 2);
            mem[3] = aop(k == 0 ? 3 : 4, 0, 1);
            run_prog(10, 1, -1);
            total++;
            if (InstAddr !== (k == 0 ? 10'd6 : 10'd4) || Done !== 1'b1) begin
                bad++;
                $display("FAIL branch_%s: addr=%0d done=%0b, want addr=%0d done=1",
                         k == 0 ? "beq" : "bne", InstAddr, Done, k == 0 ? 6 : 4);
            end
        end
    endtask

    task automatic test_latency;
        do_reset();
        fill_halt();
        mem[0] = ldi(0, 5); mem[1] = ldi(1, 3); mem[2] = aop(0, 0, 1); mem[3] = HALT;
        run_prog(10, 5, -1);
        total++;
        if (CycleCount !== 16'd24 || Done !== 1'b1) begin
            bad++;
            $display("FAIL latency: cnt=%0d done=%0b, want 24 1", CycleCount, Done);
        end
    endtask

    task automatic test_illegal;
        do_reset();
        fill_halt();
        mem[0] = ldi(0, 5); mem[1] = ldi(1, 3); mem[2] = {4'hB, 5'h0B};
        run_prog(10, 2, -1);
        total++;
        if (Error !== 1'b1 || Done !== 1'b1 || InstAddr !== 10'd2 ||
            dut.r_regs[0] !== 8'd5 || dut.r_regs[1] !== 8'd3) begin
            bad++;
            $display("FAIL illegal: err=%0b done=%0b addr=%0d r0=%0d r1=%0d, want 1 1 2 5 3",
                     Error, Done, InstAddr, dut.r_regs[0], dut.r_regs[1]);
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        fill_halt();
        mem[0] = ldi(0, 5); mem[1] = ldi(1, 3); mem[2] = aop(0, 0, 1); mem[3] = HALT;
        run_prog(10, 1, 2);
    endtask

    task automatic test_wrap;
        do_reset();
        for (int a = 0; a < 1024; a++) mem[a] = ldi(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
        halt_step = 1024;
        run_prog(1025, 1, -1);
        halt_step = -1;
        total++;
        if (InstAddr !== 10'd0 || Done !== 1'b1 || CycleCount !== 16'd2050) begin
            bad++;
            $display("FAIL wrap: addr=%0d done=%0b cnt=%0d, want 0 1 2050", InstAddr, Done, CycleCount);
        end
    endtask

    task automatic test_random;
        int k;
        for (int t = 0; t < 6; t++) begin
            do_reset();
            fill_halt();
            for (int a = 0; a < 16; a++) begin
                k = int'($urandom_range(0, 19));
                if (k < 6)       mem[a] = ldi(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
                else if (k < 8)  mem[a] = aop(int'($urandom_range(3, 4)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                else if (k < 19) mem[a] = aop(int'($urandom_range(0, 9)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                else             mem[a] = {4'(int'($urandom_range(10, 13))), 5'($urandom)};
            end
            run_prog(30, 0, -1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset_n = 1'b0; Start = 1'b0; InstValid = 1'b0; Instr = '0; noise = 1'b0;
        test_reset();
        test_basic();
        test_branch();
        test_latency();
        test_illegal();
        test_async_reset();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
